pwm_ramp_controller: RTL and testbench
======================================

// Module: pwm_ramp_controller
// PURPOSE
// - Sequences the duty_cycle input of pwm_generator: takes target-duty commands over a valid/ready handshake and ramps the applied duty toward them in bounded steps.
// - Keeps an internal period counter aligned to the generator's 2^WIDTH-cycle PWM frame; duty changes land only on frame boundaries, so no truncated or glitched pulses.
// - Provides soft-start and soft-stop: deasserting enable ramps duty down to 0 before going idle.
// PARAMETERS
// - WIDTH        8  duty/period counter width; PWM frame = 2^WIDTH clocks
// - DIV_PERIODS  4  PWM frames between successive ramp steps (>=1)
// PORTS
// - clk          in   1      system clock, all logic on rising edge
// - reset        in   1      asynchronous, active-low reset
// - enable       in   1      1 = run; 1->0 starts soft-stop ramp to 0
// - cmd_valid    in   1      target command present
// - cmd_target   in   WIDTH  requested duty target
// - cmd_ready    out  1      command accepted when cmd_valid & cmd_ready
// - step_size    in   WIDTH  duty increment per step, sampled at each step; 0 treated as 1
// - duty_cycle   out  WIDTH  registered duty to pwm_generator.duty_cycle
// - frame_sync   out  1      1-cycle pulse when period counter == 2^WIDTH-1
// - busy         out  1      1 in RAMP or STOP
// - done         out  1      1-cycle pulse on the edge duty_cycle reaches target
// BEHAVIOUR
// - Reset (reset=0): duty_cycle=0, target=0, pcnt=0, divcnt=0, state=IDLE, done=0, frame_sync=0; takes effect immediately.
// - pcnt: free-running WIDTH-bit counter, wraps 2^WIDTH-1 -> 0; frame_sync registered, high while pcnt==2^WIDTH-1; boundary = that cycle.
// - cmd_ready = enable & (state != STOP), combinational; low during reset.
// - Accept (cmd_valid & cmd_ready): target <= cmd_target, divcnt <= 0; if cmd_target != duty_cycle then state <= RAMP, else done pulses next cycle and state stays/returns IDLE.
// - Accept in RAMP retargets on the fly; direction is recomputed from the new target; divcnt restarts.
// - divcnt counts boundaries in RAMP/STOP; a step fires at the boundary where divcnt == DIV_PERIODS-1, then divcnt <= 0.
// - First step is on the DIV_PERIODS-th boundary after acceptance; an acceptance coinciding with a boundary does not count that boundary.
// - Step up   (duty < target): duty <= min(duty + s, target), computed WIDTH+1 bits wide, no wrap.
// - Step down (duty > target): duty <= (duty - target <= s) ? target : duty - s; never underflows.
// - s = (step_size==0) ? 1 : step_size.
// - duty_cycle changes only on the clock edge ending a boundary cycle, so new duty applies from pcnt==0.
// - States: IDLE (duty held) -> RAMP on accepted cmd; RAMP -> IDLE when duty reaches target (done pulse);
// -   any -> STOP when enable falls (target forced to 0); STOP steps down to 0 -> IDLE with done pulse.
// -   STOP with duty already 0: IDLE next cycle, done pulse.
// - enable re-asserted during STOP: STOP continues to 0 and ends in IDLE; cmd_ready rises only in IDLE.
// - Simultaneous accept and enable fall: enable fall wins, command dropped (cmd_ready already 0).
// - done and busy registered; busy=0 in the done cycle.
// - Reset mid-ramp: all state cleared asynchronously; duty_cycle = 0 immediately.
// TESTING
// - DIV=1, step=64, accept target=192 at pcnt=10 -> duty 64/128/192 after the next 3 boundaries; done once with the 192 update; busy low afterwards.
// - DIV=4, step=50, duty=200, target=0 -> 150,100,50,0 every 4th boundary; final step clamps to 0; no wrap to 255.
// - step=0, duty=5, target=7, DIV=1 -> 6 then 7 on consecutive boundaries (step treated as 1).
// - Ramping up to 255 at duty=128, enable->0 -> cmd_ready=0 at once; state STOP; duty ramps down to 0; done; IDLE.
// - Retarget: ramping 0->200 step 20, at duty=100 accept target=40 -> next steps 80,60,40; single done.
// - reset=0 asserted mid-ramp at duty=96 -> duty_cycle=0, frame_sync=0 without clock; after release, pcnt restarts at 0 and first frame_sync follows 2^WIDTH-1 clocks.

Source files
------------

// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller
// Drives the duty_cycle input of a 2^WIDTH-cycle PWM generator. Target duty
// commands arrive over a valid/ready handshake. The applied duty moves toward
// the target in bounded steps, once every DIV_PERIODS PWM frames. Duty updates
// land only on frame boundaries, so the generator never sees a truncated pulse.
// Dropping enable starts a soft-stop that ramps duty to zero before going idle.

module pwm_ramp_controller #(
  parameter int WIDTH       = 8,
  parameter int DIV_PERIODS = 4
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active-low
  input  logic             enable,
  input  logic             cmd_valid,
  input  logic [WIDTH-1:0] cmd_target,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] step_size,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             frame_sync,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // Frame-divider counter width; a single bit is kept even when DIV_PERIODS is 1.
  localparam int DW = (DIV_PERIODS > 1) ? $clog2(DIV_PERIODS) : 1;

  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] PCNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] PCNT_PRE = PCNT_MAX - ONE_W;
  localparam logic [DW-1:0]    DIV_ONE  = DW'(1);
  localparam logic [DW-1:0]    DIV_LAST = DW'(DIV_PERIODS - 1);

  // ---------------------------------------------------------------------------
  // Step arithmetic helpers
  // ---------------------------------------------------------------------------

  // A zero step would stall the ramp forever, so it is promoted to one.
  function automatic logic [WIDTH-1:0] eff_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    if (s == '0) begin
      r = ONE_W;
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Upward step: the sum is formed one bit wider so a large step cannot wrap
  // past the top of the range; the result is clamped at the target.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] duty,
                                               input logic [WIDTH-1:0] tgt,
                                               input logic [WIDTH-1:0] s);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    sum = {1'b0, duty} + {1'b0, s};
    if (sum >= {1'b0, tgt}) begin
      r = tgt;
    end else begin
      r = sum[WIDTH-1:0];
    end
    return r;
  endfunction

  // Downward step: the remaining gap is compared with the step first, so the
  // subtraction can never go below the target (and therefore never below 0).
  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] duty,
                                                 input logic [WIDTH-1:0] tgt,
                                                 input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] gap;
    logic [WIDTH-1:0] r;
    gap = duty - tgt;
    if (gap <= s) begin
      r = tgt;
    end else begin
      r = duty - s;
    end
    return r;
  endfunction

  // Direction is re-derived every step, so a retarget simply changes course.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] duty,
                                                   input logic [WIDTH-1:0] tgt,
                                                   input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    if (duty < tgt) begin
      r = step_up(duty, tgt, s);
    end else if (duty > tgt) begin
      r = step_down(duty, tgt, s);
    end else begin
      r = duty;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] pcnt_q,   pcnt_d;
  logic [DW-1:0]    divcnt_q, divcnt_d;
  logic [WIDTH-1:0] duty_q,   duty_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             fsync_q,  fsync_d;
  logic             done_q,   done_d;
  logic             busy_q,   busy_d;
  logic             enable_q;

  logic             ready_s;
  logic             accept_s;
  logic             fall_s;
  logic             boundary_s;
  logic             step_due_s;
  logic [WIDTH-1:0] step_val_s;

  // Handshake and event decode shared by the next-state logic.
  always_comb begin
    ready_s    = reset & enable & (state_q != ST_STOP);
    accept_s   = cmd_valid & ready_s;
    // A second fall while already stopping has nothing new to do.
    fall_s     = enable_q & ~enable & (state_q != ST_STOP);
    boundary_s = (pcnt_q == PCNT_MAX);
    step_due_s = boundary_s & (divcnt_q == DIV_LAST);
    step_val_s = step_toward(duty_q, target_q, eff_step(step_size));
  end

  // Free-running frame counter; frame_sync is registered one count early so
  // that it is high exactly while the counter sits at its last value.
  always_comb begin
    pcnt_d  = pcnt_q + ONE_W;
    fsync_d = (pcnt_q == PCNT_PRE);
  end

  // Ramp sequencer: enable fall beats a same-cycle command, a command beats a
  // same-cycle boundary (that boundary is not counted), otherwise boundaries
  // are counted and every DIV_PERIODS-th one applies a step.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    divcnt_d = divcnt_q;
    done_d   = 1'b0;

    if (fall_s) begin
      state_d  = ST_STOP;
      target_d = '0;
      divcnt_d = '0;
    end else if (accept_s) begin
      target_d = cmd_target;
      divcnt_d = '0;
      if (cmd_target != duty_q) begin
        state_d = ST_RAMP;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RAMP, ST_STOP: begin
          if ((state_q == ST_STOP) && (duty_q == '0)) begin
            state_d  = ST_IDLE;
            divcnt_d = '0;
            done_d   = 1'b1;
          end else if (step_due_s) begin
            divcnt_d = '0;
            duty_d   = step_val_s;
            if (step_val_s == target_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = state_q;
            end
          end else if (boundary_s) begin
            divcnt_d = divcnt_q + DIV_ONE;
          end else begin
            divcnt_d = divcnt_q;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          divcnt_d = '0;
        end
      endcase
    end

    busy_d = (state_d == ST_RAMP) || (state_d == ST_STOP);
  end

  // Frame counter and frame_sync registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q  <= '0;
      fsync_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      fsync_q <= fsync_d;
    end
  end

  // Sequencer state, applied duty and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      duty_q   <= '0;
      target_q <= '0;
      divcnt_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      divcnt_q <= divcnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      enable_q <= enable;
    end
  end

  assign cmd_ready  = ready_s;
  assign duty_cycle = duty_q;
  assign frame_sync = fsync_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller. Two instances share clock and reset:
// u_dut1 steps on every frame (DIV_PERIODS=1), u_dut4 every fourth frame.
// Inputs are driven and outputs sampled on the falling edge.

module tb_pwm_ramp_controller;

  logic       clk;
  logic       reset;

  logic       en1, v1, rdy1, fs1, busy1, done1;
  logic [7:0] tgt1, step1, duty1;
  logic       en4, v4, rdy4, fs4, busy4, done4;
  logic [7:0] tgt4, step4, duty4;

  int n_cmp;
  int n_err;
  int done_cnt1;

  pwm_ramp_controller #(.WIDTH(8), .DIV_PERIODS(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .enable     (en1),
    .cmd_valid  (v1),
    .cmd_target (tgt1),
    .cmd_ready  (rdy1),
    .step_size  (step1),
    .duty_cycle (duty1),
    .frame_sync (fs1),
    .busy       (busy1),
    .done       (done1)
  );

  pwm_ramp_controller #(.WIDTH(8), .DIV_PERIODS(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .enable     (en4),
    .cmd_valid  (v4),
    .cmd_target (tgt4),
    .cmd_ready  (rdy4),
    .step_size  (step4),
    .duty_cycle (duty4),
    .frame_sync (fs4),
    .busy       (busy4),
    .done       (done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses on the fast instance for the single-done checks.
  always @(negedge clk) begin
    if (reset && done1) done_cnt1 <= done_cnt1 + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Return on the falling edge inside a boundary cycle (frame_sync high).
  task automatic wait_fs(input bit sel);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ((sel ? fs4 : fs1) == 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val("frame_sync_timeout", 32'd0, 32'd1);
  endtask

  // Return on the first falling edge after a boundary, when new duty is visible.
  task automatic wait_bnd(input bit sel);
    wait_fs(sel);
    @(negedge clk);
  endtask

  // Present one command for a single cycle.
  task automatic send_cmd(input bit sel, input logic [7:0] t, input logic [7:0] s);
    if (sel) begin
      tgt4 = t; step4 = s; v4 = 1'b1;
    end else begin
      tgt1 = t; step1 = s; v1 = 1'b1;
    end
    @(negedge clk);
    v1 = 1'b0;
    v4 = 1'b0;
  endtask

  initial begin
    int n;
    int snap;
    n_cmp = 0; n_err = 0; done_cnt1 = 0;
    reset = 1'b0;
    en1 = 1'b1; v1 = 1'b0; tgt1 = 8'd0; step1 = 8'd1;
    en4 = 1'b1; v4 = 1'b0; tgt4 = 8'd0; step4 = 8'd1;

    // Reset state, with enable already high.
    repeat (2) @(negedge clk);
    check_val("rst_duty", {24'd0, duty1}, 32'd0);
    check_val("rst_fsync", {31'd0, fs1}, 32'd0);
    check_val("rst_busy", {31'd0, busy1}, 32'd0);
    check_val("rst_done", {31'd0, done1}, 32'd0);
    check_val("rst_ready", {31'd0, rdy1}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_val("idle_ready", {31'd0, rdy1}, 32'd1);

    // Target equal to current duty: immediate done, stays idle.
    send_cmd(1'b0, 8'd0, 8'd1);
    check_val("eq_done", {31'd0, done1}, 32'd1);
    check_val("eq_busy", {31'd0, busy1}, 32'd0);

    // DIV=1, step 64, target 192 accepted at pcnt=10.
    wait_fs(1'b0);
    repeat (11) @(negedge clk);
    send_cmd(1'b0, 8'd192, 8'd64);
    check_val("t1_busy", {31'd0, busy1}, 32'd1);
    wait_fs(1'b0);
    check_val("t1_hold_in_bnd", {24'd0, duty1}, 32'd0);
    @(negedge clk);
    check_val("t1_step1", {24'd0, duty1}, 32'd64);
    check_val("t1_no_done1", {31'd0, done1}, 32'd0);
    wait_bnd(1'b0);
    check_val("t1_step2", {24'd0, duty1}, 32'd128);
    wait_bnd(1'b0);
    check_val("t1_step3", {24'd0, duty1}, 32'd192);
    check_val("t1_done", {31'd0, done1}, 32'd1);
    check_val("t1_busy_done", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    check_val("t1_done_pulse", {31'd0, done1}, 32'd0);

    // Step 0 treated as 1: 5 -> 6 -> 7.
    send_cmd(1'b0, 8'd5, 8'd255);
    wait_bnd(1'b0);
    check_val("t3_to5", {24'd0, duty1}, 32'd5);
    send_cmd(1'b0, 8'd7, 8'd0);
    wait_bnd(1'b0);
    check_val("t3_six", {24'd0, duty1}, 32'd6);
    check_val("t3_busy", {31'd0, busy1}, 32'd1);
    wait_bnd(1'b0);
    check_val("t3_seven", {24'd0, duty1}, 32'd7);
    check_val("t3_done", {31'd0, done1}, 32'd1);

    // Retarget mid-ramp: 0 -> 200 step 20, at 100 retarget to 40.
    send_cmd(1'b0, 8'd0, 8'd255);
    wait_bnd(1'b0);
    check_val("t5_zero", {24'd0, duty1}, 32'd0);
    send_cmd(1'b0, 8'd200, 8'd20);
    repeat (5) wait_bnd(1'b0);
    check_val("t5_at100", {24'd0, duty1}, 32'd100);
    snap = done_cnt1;
    send_cmd(1'b0, 8'd40, 8'd20);
    for (int k = 1; k <= 3; k++) begin
      wait_bnd(1'b0);
      check_val("t5_down", {24'd0, duty1}, 32'(100 - 20 * k));
    end
    @(negedge clk);
    check_val("t5_single_done", 32'(done_cnt1 - snap), 32'd1);

    // Soft stop from 128 while ramping to 255; command on the falling edge dropped.
    send_cmd(1'b0, 8'd255, 8'd8);
    for (int k = 1; k <= 11; k++) begin
      wait_bnd(1'b0);
      check_val("t4_up", {24'd0, duty1}, 32'(40 + 8 * k));
    end
    en1 = 1'b0; v1 = 1'b1; tgt1 = 8'd10;
    #1;
    check_val("t4_ready_drop", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    v1 = 1'b0;
    check_val("t4_stop_busy", {31'd0, busy1}, 32'd1);
    check_val("t4_stop_hold", {24'd0, duty1}, 32'd128);
    wait_bnd(1'b0);
    check_val("t4_first_down", {24'd0, duty1}, 32'd120);
    en1 = 1'b1;
    #1;
    check_val("t4_ready_in_stop", {31'd0, rdy1}, 32'd0);
    for (int k = 2; k <= 16; k++) begin
      wait_bnd(1'b0);
      check_val("t4_down", {24'd0, duty1}, 32'(128 - 8 * k));
    end
    check_val("t4_done", {31'd0, done1}, 32'd1);
    check_val("t4_idle_busy", {31'd0, busy1}, 32'd0);
    check_val("t4_ready_idle", {31'd0, rdy1}, 32'd1);

    // DIV=4: accept on a boundary (not counted), reach 200, then 200 -> 0 step 50.
    wait_fs(1'b1);
    send_cmd(1'b1, 8'd200, 8'd200);
    for (int k = 1; k <= 4; k++) begin
      wait_bnd(1'b1);
      check_val("t2_up", {24'd0, duty4}, (k < 4) ? 32'd0 : 32'd200);
    end
    check_val("t2_up_done", {31'd0, done4}, 32'd1);
    send_cmd(1'b1, 8'd0, 8'd50);
    for (int k = 1; k <= 16; k++) begin
      wait_bnd(1'b1);
      check_val("t2_down", {24'd0, duty4}, 32'(200 - 50 * (k / 4)));
    end
    check_val("t2_done", {31'd0, done4}, 32'd1);
    repeat (4) wait_bnd(1'b1);
    check_val("t2_no_wrap", {24'd0, duty4}, 32'd0);

    // Reset mid-ramp at 96, then frame counter restart.
    send_cmd(1'b0, 8'd200, 8'd32);
    repeat (3) wait_bnd(1'b0);
    check_val("t6_at96", {24'd0, duty1}, 32'd96);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("t6_duty_async", {24'd0, duty1}, 32'd0);
    check_val("t6_fsync_async", {31'd0, fs1}, 32'd0);
    check_val("t6_busy_async", {31'd0, busy1}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (fs1) begin
        n = i;
        break;
      end
    end
    check_val("t6_first_fsync", 32'(n), 32'd255);
    check_val("t6_duty_after", {24'd0, duty1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case a wait never resolves.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
